// File: rtl/mux_arb_n_w.sv
// rtl/mux_arb_n_w.sv - N-way registered mux with external-select or round-robin grant
// Define MUX_ARB_XFER_CNT_EN to add the 16-bit xfer_cnt input-transfer counter output.
module mux_arb_n_w #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MUX_ARB_XFER_CNT_EN
  output logic [SEL_W-1:0]        out_src,
  output logic [15:0]             xfer_cnt
`else
  output logic [SEL_W-1:0]        out_src
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new beat when empty or when it drains this cycle.
  assign load_en   = (state == ST_EMPTY) || out_ready;
  assign out_valid = (state == ST_FULL);

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      if ((int'(sel) < NUM_IN) && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // Search starts one past the last winner; the last winner is considered last.
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_IN;
        if (!grant_vld && in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  assign grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (rst_n && grant_vld && load_en)
      in_ready[grant_idx] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      state    <= ST_FULL;
      out_data <= grant_data;
      out_src  <= grant_idx;
      if (mode)
        rr_ptr <= grant_idx;
    end else if (out_ready) begin
      state <= ST_EMPTY;
    end
  end

`ifdef MUX_ARB_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (xfer)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_arb_n_w.sv
// tb/tb_mux_arb_n_w.sv - directed scoreboard bench for mux_arb_n_w
module tb_mux_arb_n_w;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel = '0;
  logic           mode = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_src;
`ifdef MUX_ARB_XFER_CNT_EN
  logic [15:0]    xfer_cnt;
`endif

  beat_t sb[$];
  beat_t mon_e;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_xfer = 0;

  mux_arb_n_w #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX_ARB_XFER_CNT_EN
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
`else
    .out_src   (out_src)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_src", out_src, mon_e.s);
      end
    end
  end

  // One cycle: check in_ready and out_valid mid-cycle, queue the beat that transfers.
  task automatic cyc(input string nm, input logic [N-1:0] exp_rdy, input logic exp_ov);
    @(negedge clk);
    chk({nm, "_rdy"}, in_ready, exp_rdy);
    chk({nm, "_ov"}, out_valid, exp_ov);
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i] && in_valid[i]) begin
        sb.push_back({in_data[i*W +: W], SW'(i)});
        n_xfer++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = 32'hA000_0000 + i;

    // Reset state, with requests present to show in_ready is gated
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #12;
    chk("rst_rdy", in_ready, 4'b0000);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_src", out_src, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 4'b0000;

    // External select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2*W +: W] = 32'hDEADBEEF;
    cyc("t033", 4'b0100, 1'b0);
    in_valid = 4'b0000;
    cyc("t033_drain", 4'b0000, 1'b1);

    // Round robin from reset pointer, full throughput
    mode = 1'b1; in_valid = 4'b1111;
    cyc("rr0", 4'b0001, 1'b0);
    cyc("rr1", 4'b0010, 1'b1);
    cyc("rr2", 4'b0100, 1'b1);
    cyc("rr3", 4'b1000, 1'b1);
    cyc("rr4", 4'b0001, 1'b1);
    in_valid = 4'b0000;
    cyc("rr_drain", 4'b0000, 1'b1);

    // Backpressure hold with external select of channel 1
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    in_data[1*W +: W] = 32'h1111_1111;
    cyc("hold_load", 4'b0010, 1'b0);
    in_data[1*W +: W] = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      cyc("hold", 4'b0000, 1'b1);
      chk("hold_data", out_data, 32'h1111_1111);
      chk("hold_src", out_src, 2'd1);
    end
    out_ready = 1'b1;
    cyc("hold_release", 4'b0010, 1'b1);
    in_valid = 4'b0000;
    cyc("hold_drain", 4'b0000, 1'b1);

    // Select of a channel that is not valid
    sel = 2'd3; in_valid = 4'b0111;
    cyc("nogrant0", 4'b0000, 1'b0);
    cyc("nogrant1", 4'b0000, 1'b0);

    // Round robin resumes from pointer 0 (mode-0 transfers left it alone), wraps
    mode = 1'b1;
    in_valid = 4'b0011; cyc("rrp1", 4'b0010, 1'b0);
    in_valid = 4'b0101; cyc("rrp2", 4'b0100, 1'b1);
    in_valid = 4'b0011; cyc("rrwrap", 4'b0001, 1'b1);
    in_valid = 4'b0001; cyc("rrself", 4'b0001, 1'b1);
    in_valid = 4'b0000; cyc("rrp_drain", 4'b0000, 1'b1);

    // Reset while full discards the held beat
    in_valid = 4'b1111; out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rdy", in_ready, 4'b0010);
    @(posedge clk); #2;
    chk("pre_rst_ov", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_src", out_src, 2'd0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_rdy", in_ready, 4'b0000);
    n_xfer = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    cyc("post_rst", 4'b0001, 1'b0);
    in_valid = 4'b0000;
    cyc("post_rst_drain", 4'b0000, 1'b1);
    cyc("post_rst_idle", 4'b0000, 1'b0);

    chk("sb_empty", sb.size(), 0);
`ifdef MUX_ARB_XFER_CNT_EN
    chk("xfer_cnt", xfer_cnt, n_xfer[15:0]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
